// File: rtl/button_event_decoder_pkg.sv
// Shared types and constants for the button event decoder.
// Holds the FSM state encoding and the default counter width.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 26;

endpackage

// File: rtl/button_event_timer.sv
// event_timer: CNT_W cycle counter with clear/increment and
// terminal compare. Ports: clk, reset, clr, inc, term -> done.
module event_timer
  import button_event_decoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/long/repeat
// pulses and a held level. Ports: clk, reset, enable, debounced ->
// press_pulse, release_pulse, long_pulse, repeat_pulse, held.
// Define BUTTON_AUTO_REPEAT_EN to enable auto-repeat while held.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TERM =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TERM =
    CNT_W'(REPEAT_CYCLES - 1);

  state_t state;
  state_t nxt;

  logic clr;
  logic inc;
  logic done;
  logic [CNT_W-1:0] term;

  logic press_d;
  logic release_d;
  logic long_d;
  logic repeat_d;
  logic held_d;

  event_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .term  (term),
    .done  (done)
  );

  assign term = (state == HELD) ? REP_TERM : LONG_TERM;

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= nxt;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

  // next state and timer control
  always_comb begin
    nxt = state;
    clr = 1'b0;
    inc = 1'b0;
    if (!enable) begin
      nxt = IDLE;
      clr = 1'b1;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (debounced) begin
            nxt = PRESSED;
            clr = 1'b1;
          end
        end
        (state == PRESSED): begin
          if (!debounced) begin
            nxt = IDLE;
            clr = 1'b1;
          end else if (done) begin
            nxt = HELD;
            clr = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
        (state == HELD): begin
          if (!debounced) begin
            nxt = IDLE;
            clr = 1'b1;
          end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
            if (done) clr = 1'b1;
            else      inc = 1'b1;
`endif
          end
        end
        default: begin
          nxt = IDLE;
          clr = 1'b1;
        end
      endcase
    end
  end

  // next output values; release is checked before terminal
  // count so a simultaneous release suppresses long/repeat
  always_comb begin
    press_d   = enable && (state == IDLE) && debounced;
    release_d = enable && (state != IDLE) && !debounced;
    long_d    = enable && (state == PRESSED) && debounced && done;
`ifdef BUTTON_AUTO_REPEAT_EN
    repeat_d  = enable && (state == HELD) && debounced && done;
`else
    repeat_d  = 1'b0;
`endif
    held_d    = (nxt == HELD);
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized self-checking bench for button_event_decoder
// against a press-age reference model.
module tb_button_event_decoder;

  localparam int LONG = 10;
  localparam int REP  = 4;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic debounced;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_active = 1'b0;
  int m_age    = 0;
  bit e_press, e_rel, e_long, e_rep, e_held;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  task automatic check(input string tag, input logic obs,
                       input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b",
               tag, $time, obs, exp);
    end
  endtask

  // Model: age = edges since the press edge while a press is live.
  task automatic model(input logic r, input logic e,
                       input logic d);
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    if (r || !e) begin
      m_active = 0;
    end else if (!m_active) begin
      if (d) begin
        m_active = 1;
        m_age    = 0;
        e_press  = 1;
      end
    end else if (!d) begin
      m_active = 0;
      e_rel    = 1;
    end else begin
      m_age++;
      e_long = (m_age == LONG);
      e_rep  = REP_EN && (m_age > LONG) &&
               ((m_age - LONG) % REP == 0);
    end
    e_held = m_active && (m_age >= LONG);
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      reset = r; enable = e; debounced = d;
      @(posedge clk);
      model(r, e, d);
      #1;
      check("press",   press_pulse,   e_press);
      check("release", release_pulse, e_rel);
      check("long",    long_pulse,    e_long);
      check("repeat",  repeat_pulse,  e_rep);
      check("held",    held,          e_held);
    end
  endtask

  initial begin
    int run;
    bit lvl;
    // reset state
    cyc(1, 1, 1, 3);
    cyc(0, 1, 0, 3);
    // short press
    cyc(0, 1, 1, 5);
    cyc(0, 1, 0, 3);
    // long press with repeat
    cyc(0, 1, 1, 20);
    cyc(0, 1, 0, 3);
    // release racing the long terminal count
    cyc(0, 1, 1, LONG);
    cyc(0, 1, 0, 3);
    // enable dropped while held, re-raised with button down
    cyc(0, 1, 1, 12);
    cyc(0, 0, 1, 3);
    cyc(0, 1, 1, 4);
    cyc(0, 1, 0, 2);
    // reset mid-press
    cyc(0, 1, 1, 6);
    cyc(1, 1, 1, 2);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 0, 2);
    // long hold
    cyc(0, 1, 1, 30);
    cyc(0, 1, 0, 2);
    // random runs
    lvl = 0;
    for (int k = 0; k < 300; k++) begin
      run = $urandom_range(1, 25);
      lvl = ~lvl;
      if ($urandom_range(0, 29) == 0)
        cyc(1, 1, lvl, $urandom_range(1, 3));
      else if ($urandom_range(0, 14) == 0)
        cyc(0, 0, lvl, $urandom_range(1, 4));
      cyc(0, 1, lvl, run);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
